writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Registers the instruction leaving memory and captures the synchronous data-SRAM read word in the cycle after the request.
- Aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR) and commits one register-file write per instruction.
- Drives bypass, debug-trace and retire-count outputs.

Parameters:
- PC_W, 32, width of PC carried for debug trace
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock; single clock domain
- resetn  in  1  reset, asynchronous, active-low
- mem_to_wb_valid  in  1  memory stage holds a valid instruction
- wb_allowin  out  1  writeback can accept this cycle
- mem_pc  in  PC_W  instruction PC
- mem_load_type  in  3  load kind; encoding in package
- mem_addr_low  in  2  data address bits [1:0]
- mem_rt_old  in  32  old rt value, for LWL/LWR merge
- mem_result  in  32  ALU/HI/LO result for non-loads
- mem_rf_wen  in  1  instruction writes a register
- mem_rf_waddr  in  5  destination register
- data_sram_rdata  in  32  SRAM read word; valid the cycle after the read request
- wb_stall  in  1  external hold (trace back-pressure)
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- wb_fwd_valid  out  1  bypass candidate present (wb_valid and wen and waddr!=0)
- wb_fwd_waddr  out  5  bypass destination
- wb_fwd_wdata  out  32  bypass data; equal to rf_wdata
- debug_wb_pc  out  PC_W  committing PC
- debug_wb_rf_wen  out  4  4'hf on commit write, else 0
- debug_wb_rf_wnum  out  5  equal to rf_waddr
- debug_wb_rf_wdata  out  32  equal to rf_wdata
- retire_cnt  out  CNT_W  instructions committed since reset

Behaviour:
- Reset (async, resetn=0): wb_valid=0, all pipeline registers=0, rdata_buf_valid=0, retire_cnt=0. Every output is therefore 0, except wb_allowin=1.
- Handshake:
  - ready_go = !wb_stall.
  - wb_allowin = !wb_valid | ready_go.
  - On a rising edge with wb_allowin=1: wb_valid<=mem_to_wb_valid; when mem_to_wb_valid=1, all mem_* fields are also latched.
- Commit = wb_valid & ready_go; exactly one commit per instruction. Latency is 1 cycle from acceptance to commit when not stalled.
- rf_wen = commit & wb_rf_wen & (wb_rf_waddr!=0). Writes to $0 are suppressed, and debug_wb_rf_wen is also 0 for them.
- Read-data hold:
  - rdata_sel = rdata_buf_valid ? rdata_buf : data_sram_rdata.
  - If wb_valid & !ready_go & !rdata_buf_valid: rdata_buf<=data_sram_rdata and rdata_buf_valid<=1.
  - rdata_buf_valid clears on any acceptance (wb_allowin & mem_to_wb_valid) or when wb_valid falls.
  - This protects against the memory stage issuing a new read while writeback is stalled.
- Load alignment (little-endian, o=wb_addr_low):
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: halfword o[1], sign- or zero-extended. o[0] is ignored; alignment faults are handled upstream.
  - LW: full word.
  - LWL o=0..3: {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
  - LWR o=0..3: m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.
  - NONE: wdata = wb_result.
- Bypass outputs are valid whenever wb_valid, including during a stall, so decode sees the pending value.
- retire_cnt increments by 1 on every commit, including commits with no register write. It wraps modulo 2^CNT_W.
- Simultaneous commit and accept is permitted: the new instruction is latched in the same edge that the old one commits.
- Reset asserted mid-stall: the held instruction is discarded with no write and no count.

Decomposition:
- Package cpu_defs_pkg holds:
  - Load-type localparams: LT_NONE=0, LT_LB=1, LT_LBU=2, LT_LH=3, LT_LHU=4, LT_LW=5, LT_LWL=6, LT_LWR=7.
  - Register-number width (5).
- Sub-module load_align: combinational, inputs (load_type, addr_low, rdata, rt_old, result), output wdata. It is reused by any future bypass-of-load logic.

Test Plan:
- LB, addr_low=2, rdata=32'h12_80_34_56 -> rf_wdata=32'hFFFFFF80, rf_wen=1 one cycle after acceptance; LBU, same inputs -> 32'h00000080.
- LWL, o=1, rdata=32'hAABBCCDD, rt_old=32'h11223344 -> 32'hCCDD3344; LWR, o=2, same inputs -> 32'h1122AABB.
- LW accepted, rdata=32'hDEADBEEF in cycle 1; wb_stall=1 for 3 cycles while rdata changes to 32'h0 -> commits 32'hDEADBEEF, single rf_wen pulse, wb_allowin=0 during the stall.
- Non-load with mem_rf_waddr=0, result=32'h5 -> rf_wen=0, debug_wb_rf_wen=0, retire_cnt increments by 1.
- Back-to-back 4 valid instructions with no stall -> 4 consecutive commit cycles, wb_allowin stays 1, retire_cnt=4.
- resetn pulled low while stalled holding a load -> all outputs 0 immediately (async); after release no write occurs and retire_cnt=0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: load-type encoding, register-number width and the
// instruction record carried from memory into writeback.
package cpu_defs_pkg;

    localparam int REG_W = 5;
    localparam int LT_W  = 3;

    typedef logic [LT_W-1:0] load_type_t;

    localparam load_type_t LT_NONE = 3'd0;
    localparam load_type_t LT_LB   = 3'd1;
    localparam load_type_t LT_LBU  = 3'd2;
    localparam load_type_t LT_LH   = 3'd3;
    localparam load_type_t LT_LHU  = 3'd4;
    localparam load_type_t LT_LW   = 3'd5;
    localparam load_type_t LT_LWL  = 3'd6;
    localparam load_type_t LT_LWR  = 3'd7;

    // Everything writeback needs from memory except the parameterised PC.
    typedef struct packed {
        load_type_t       load_type;
        logic [1:0]       addr_low;
        logic [31:0]      rt_old;
        logic [31:0]      result;
        logic             rf_wen;
        logic [REG_W-1:0] rf_waddr;
    } wb_inst_t;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: selects, extends or merges the data-SRAM
// word according to load type and address offset (little-endian).
module load_align
    import cpu_defs_pkg::*;
(
    input  load_type_t  load_type,
    input  logic [1:0]  addr_low,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    input  logic [31:0] result,
    output logic [31:0] wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_data;
    logic [31:0] lwr_data;

    assign byte_sel = rdata[{addr_low, 3'b000} +: 8];
    assign half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

    // LWL fills the upper bytes from memory, LWR the lower bytes; the rest keep rt.
    always_comb begin
        unique case (addr_low)
            2'd0:    lwl_data = {rdata[7:0],  rt_old[23:0]};
            2'd1:    lwl_data = {rdata[15:0], rt_old[15:0]};
            2'd2:    lwl_data = {rdata[23:0], rt_old[7:0]};
            default: lwl_data = rdata;
        endcase
    end

    always_comb begin
        unique case (addr_low)
            2'd0:    lwr_data = rdata;
            2'd1:    lwr_data = {rt_old[31:24], rdata[31:8]};
            2'd2:    lwr_data = {rt_old[31:16], rdata[31:16]};
            default: lwr_data = {rt_old[31:8],  rdata[31:24]};
        endcase
    end

    always_comb begin
        // NOTE: default assigned before the case so no path leaves wdata unassigned (no latch).
        wdata = result;
        case (load_type)
            LT_LB:   wdata = ext8(byte_sel, 1'b1);
            LT_LBU:  wdata = ext8(byte_sel, 1'b0);
            LT_LH:   wdata = ext16(half_sel, 1'b1);
            LT_LHU:  wdata = ext16(half_sel, 1'b0);
            LT_LW:   wdata = rdata;
            LT_LWL:  wdata = lwl_data;
            LT_LWR:  wdata = lwr_data;
            default: wdata = result;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers the instruction from memory, holds the SRAM
// read word across stalls, aligns load data and commits one RF write per instruction.
module writeback_stage
    import cpu_defs_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_to_wb_valid,
    output logic              wb_allowin,
    input  logic [PC_W-1:0]   mem_pc,
    input  logic [LT_W-1:0]   mem_load_type,
    input  logic [1:0]        mem_addr_low,
    input  logic [31:0]       mem_rt_old,
    input  logic [31:0]       mem_result,
    input  logic              mem_rf_wen,
    input  logic [REG_W-1:0]  mem_rf_waddr,
    input  logic [31:0]       data_sram_rdata,
    input  logic              wb_stall,
    output logic              rf_wen,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              wb_fwd_valid,
    output logic [REG_W-1:0]  wb_fwd_waddr,
    output logic [31:0]       wb_fwd_wdata,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [REG_W-1:0]  debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic             wb_valid_q,        wb_valid_d;
    logic [PC_W-1:0]  wb_pc_q,           wb_pc_d;
    wb_inst_t         wb_inst_q,         wb_inst_d;
    logic [31:0]      rdata_buf_q,       rdata_buf_d;
    logic             rdata_buf_valid_q, rdata_buf_valid_d;
    logic [CNT_W-1:0] retire_cnt_q,      retire_cnt_d;

    logic        ready_go;
    logic        commit;
    logic        wen_nz;
    logic [31:0] rdata_sel;
    logic [31:0] wdata;

    assign ready_go   = !wb_stall;
    assign wb_allowin = !wb_valid_q || ready_go;
    assign commit     = wb_valid_q && ready_go;
    assign rdata_sel  = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

    always_comb begin
        wb_valid_d        = wb_valid_q;
        wb_pc_d           = wb_pc_q;
        wb_inst_d         = wb_inst_q;
        rdata_buf_d       = rdata_buf_q;
        rdata_buf_valid_d = rdata_buf_valid_q;
        retire_cnt_d      = retire_cnt_q;

        if (wb_allowin) begin
            wb_valid_d = mem_to_wb_valid;
            // Any edge that lets writeback move on either accepts a new
            // instruction or empties the stage, so the held word is stale.
            rdata_buf_valid_d = 1'b0;
            if (mem_to_wb_valid) begin
                wb_pc_d   = mem_pc;
                wb_inst_d = '{load_type: load_type_t'(mem_load_type),
                              addr_low:  mem_addr_low,
                              rt_old:    mem_rt_old,
                              result:    mem_result,
                              rf_wen:    mem_rf_wen,
                              rf_waddr:  mem_rf_waddr};
            end
        end else if (!rdata_buf_valid_q) begin
            // First stalled cycle: the SRAM word is valid only now, so keep it.
            rdata_buf_d       = data_sram_rdata;
            rdata_buf_valid_d = 1'b1;
        end

        if (commit) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q        <= 1'b0;
            wb_pc_q           <= '0;
            wb_inst_q         <= '0;
            rdata_buf_q       <= '0;
            rdata_buf_valid_q <= 1'b0;
            retire_cnt_q      <= '0;
        end else begin
            wb_valid_q        <= wb_valid_d;
            wb_pc_q           <= wb_pc_d;
            wb_inst_q         <= wb_inst_d;
            rdata_buf_q       <= rdata_buf_d;
            rdata_buf_valid_q <= rdata_buf_valid_d;
            retire_cnt_q      <= retire_cnt_d;
        end
    end

    load_align u_load_align (
        .load_type (wb_inst_q.load_type),
        .addr_low  (wb_inst_q.addr_low),
        .rdata     (rdata_sel),
        .rt_old    (wb_inst_q.rt_old),
        .result    (wb_inst_q.result),
        .wdata     (wdata)
    );

    // $0 is hardwired; a write to it is neither committed nor forwarded.
    assign wen_nz = wb_inst_q.rf_wen && (wb_inst_q.rf_waddr != '0);

    assign rf_wen            = commit && wen_nz;
    assign rf_waddr          = wb_inst_q.rf_waddr;
    assign rf_wdata          = wdata;

    assign wb_fwd_valid      = wb_valid_q && wen_nz;
    assign wb_fwd_waddr      = wb_inst_q.rf_waddr;
    assign wb_fwd_wdata      = wdata;

    assign debug_wb_pc       = wb_pc_q;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = wb_inst_q.rf_waddr;
    assign debug_wb_rf_wdata = wdata;

    assign retire_cnt        = retire_cnt_q;

endmodule
